lfsr_channel_blinker: RTL and testbench

Parametrised successor to the single-toggle LFSR/demux LED driver: a W-bit XNOR LFSR sets a blink period of 2^W−1 clocks, and the resulting tick drives N output channels in one of four modes (route, chase, all, off). It sits between the board switches/config and the LED pins, and replaces the fixed 22-bit, 4-output arrangement with a generic block.

---
 rtl/lfsr_channel_blinker_pkg.sv | 19 +
 rtl/lfsr_channel_blinker_lfsr_param.sv | 42 ++++
 rtl/lfsr_channel_blinker.sv | 83 ++++++++
 tb/tb_lfsr_channel_blinker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lfsr_channel_blinker_pkg.sv
// Shared definitions for the LFSR channel blinker: mode encodings and
// known maximal-length XNOR tap masks for common LFSR widths.
package lfsr_channel_blinker_pkg;

    typedef enum logic [1:0] {
        MODE_ROUTE = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_ALL   = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    // Bit i set = LFSR bit i feeds the XNOR; all include the MSB.
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hD008;
    localparam logic [21:0] TAPS_W22 = 22'h300000;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_channel_blinker_lfsr_param.sv
// Generic W-bit XNOR LFSR (shift left, feedback into bit 0) with a registered
// pulse marking each return to the all-zeros start state.
module lfsr_param
    import lfsr_channel_blinker_pkg::*;
#(
    parameter int             W    = 22,
    parameter logic [W-1:0]   TAPS = TAPS_W22
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Enable,
    output logic [W-1:0] o_LFSR_Data,
    output logic         o_Tick
);

    logic [W-1:0] lfsr_q, lfsr_d;
    logic         tick_q, tick_d;
    logic         feedback;

    always_comb begin
        feedback = ~^(lfsr_q & TAPS);
        lfsr_d   = lfsr_q;
        if (i_Enable) begin
            lfsr_d = {lfsr_q[W-2:0], feedback};
        end
        tick_d = i_Enable && (lfsr_d == '0);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            lfsr_q <= '0;
            tick_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            tick_q <= tick_d;
        end
    end

    assign o_LFSR_Data = lfsr_q;
    assign o_Tick      = tick_q;

endmodule

// File: rtl/lfsr_channel_blinker.sv
// LED blinker: LFSR period timer driving N channels in route/chase/all/off
// modes, with toggle, chase index and registered output decode.
module lfsr_channel_blinker
    import lfsr_channel_blinker_pkg::*;
#(
    parameter int           W     = 22,
    parameter logic [W-1:0] TAPS  = TAPS_W22,
    parameter int           N     = 4,
    parameter int           SEL_W = $clog2(N)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Enable,
    input  logic [1:0]       i_Mode,
    input  logic [SEL_W-1:0] i_Sel,
    output logic [N-1:0]     o_Chan,
    output logic             o_Tick,
    output logic [W-1:0]     o_LFSR_Data
);

    // With the MSB in the taps, the only state that advances to all-zeros
    // is 100..0, so the wrap is known one cycle ahead of the registered tick.
    localparam logic [W-1:0] WRAP_STATE = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]     lfsr_data;
    logic             tick;
    logic             wrap;
    logic             toggle_q, toggle_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     chan_q, chan_d;

    lfsr_param #(
        .W    (W),
        .TAPS (TAPS)
    ) u_lfsr (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Enable    (i_Enable),
        .o_LFSR_Data (lfsr_data),
        .o_Tick      (tick)
    );

    assign wrap = i_Enable && (lfsr_data == WRAP_STATE);

    always_comb begin
        toggle_d = toggle_q ^ wrap;
        idx_d    = idx_q;
        if (wrap) begin
            idx_d = (idx_q == SEL_W'(N - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        chan_d = '0;
        case (mode_e'(i_Mode))
            MODE_ROUTE: begin
                if ({1'b0, i_Sel} < (SEL_W + 1)'(N)) begin
                    chan_d[i_Sel] = toggle_q;
                end
            end
            MODE_CHASE: chan_d[idx_q] = 1'b1;
            MODE_ALL:   chan_d = {N{toggle_q}};
            default:    chan_d = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            toggle_q <= 1'b0;
            idx_q    <= '0;
            chan_q   <= '0;
        end else begin
            toggle_q <= toggle_d;
            idx_q    <= idx_d;
            chan_q   <= chan_d;
        end
    end

    assign o_Chan      = chan_q;
    assign o_Tick      = tick;
    assign o_LFSR_Data = lfsr_data;

endmodule

// File: tb/tb_lfsr_channel_blinker.sv
// Directed bench for lfsr_channel_blinker at W=4, TAPS=4'hC, N=4.
module tb_lfsr_channel_blinker;
    import lfsr_channel_blinker_pkg::*;

    logic       clk;
    logic       rst_l;
    logic       en;
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] chan;
    logic       tick;
    logic [3:0] lfsr;

    int checks   = 0;
    int failures = 0;

    int seq [16] = '{0, 1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8, 0};

    lfsr_channel_blinker #(
        .W    (4),
        .TAPS (4'hC),
        .N    (4)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Enable    (en),
        .i_Mode      (mode),
        .i_Sel       (sel),
        .o_Chan      (chan),
        .o_Tick      (tick),
        .o_LFSR_Data (lfsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l = 1'b0;
        en    = 1'b0;
        mode  = MODE_OFF;
        sel   = 2'd0;

        // reset state
        step(2);
        chk("rst_chan", 32'(chan), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_lfsr", 32'(lfsr), 32'h0);

        // first period: sequence, single tick, no lock-up, route still dark
        rst_l = 1'b1;
        en    = 1'b1;
        mode  = MODE_ROUTE;
        sel   = 2'd2;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("lfsr_seq", 32'(lfsr), 32'(seq[k]));
            chk("tick_seq", 32'(tick), 32'(k == 15));
            chk("no_lockup", 32'(lfsr == 4'hF), 32'h0);
            chk("route_dark", 32'(chan), 32'h0);
        end

        // route sel=2: lit for 15 cycles starting one after the first tick
        for (int k = 16; k <= 31; k++) begin
            step(1);
            chk("route_chan", 32'(chan), (k <= 30) ? 32'h4 : 32'h0);
            chk("route_tick", 32'(tick), 32'(k == 30));
        end

        // chase: index is 2 after two ticks; steps on every later tick
        mode = MODE_CHASE;
        step(1);   // enabled cycle 32
        chk("chase_idx2", 32'(chan), 32'h4);
        step(13);  // 45
        chk("chase_tick45", 32'(tick), 32'h1);
        chk("chase_pre45", 32'(chan), 32'h4);
        step(1);   // 46
        chk("chase_1000", 32'(chan), 32'h8);
        step(15);  // 61
        chk("chase_0001", 32'(chan), 32'h1);
        step(15);  // 76
        chk("chase_0010", 32'(chan), 32'h2);
        step(15);  // 91
        chk("chase_0100", 32'(chan), 32'h4);
        chk("lfsr_at91", 32'(lfsr), 32'h1);

        // enable low for 10 cycles: everything holds, tick delayed by 10
        en = 1'b0;
        step(10);
        chk("hold_lfsr", 32'(lfsr), 32'h1);
        chk("hold_tick", 32'(tick), 32'h0);
        chk("hold_chan", 32'(chan), 32'h4);
        en = 1'b1;
        step(13);
        chk("delay_pre_tick", 32'(tick), 32'h0);
        chk("delay_pre_lfsr", 32'(lfsr), 32'h8);
        step(1);
        chk("delay_tick", 32'(tick), 32'h1);
        chk("delay_lfsr", 32'(lfsr), 32'h0);

        // all/off/all: toggle is 1 after seven ticks; LFSR keeps advancing
        mode = MODE_ALL;
        step(1);
        chk("all_on", 32'(chan), 32'hF);
        chk("all_lfsr1", 32'(lfsr), 32'h1);
        mode = MODE_OFF;
        step(1);
        chk("off", 32'(chan), 32'h0);
        chk("off_lfsr", 32'(lfsr), 32'h3);
        mode = MODE_ALL;
        step(1);
        chk("all_again", 32'(chan), 32'hF);
        chk("all_lfsr7", 32'(lfsr), 32'h7);

        // reset mid-period at LFSR=9 (toggle=1, idx=3), enable still high
        step(6);
        chk("pre_rst_lfsr", 32'(lfsr), 32'h9);
        rst_l = 1'b0;
        step(1);
        chk("midrst_chan", 32'(chan), 32'h0);
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_lfsr", 32'(lfsr), 32'h0);
        rst_l = 1'b1;
        mode  = MODE_CHASE;
        step(1);
        chk("midrst_idx0", 32'(chan), 32'h1);
        chk("midrst_lfsr1", 32'(lfsr), 32'h1);
        mode = MODE_ALL;
        step(1);
        chk("midrst_tog0", 32'(chan), 32'h0);
        step(12);
        chk("midrst_pre_tick", 32'(tick), 32'h0);
        chk("midrst_pre_lfsr", 32'(lfsr), 32'h8);
        step(1);
        chk("midrst_tick15", 32'(tick), 32'h1);
        step(1);
        chk("midrst_all_on", 32'(chan), 32'hF);
        chk("midrst_tick_end", 32'(tick), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
